// File: rtl/warp_controller.sv
// Per-warp instruction sequencer: fetch, decode, operand request, optional LSU wait, execute, PC update.
// Latency: one state per cycle; FETCH stalls until fetch_valid (bounded by FETCH_TIMEOUT), WAIT until lsu_done.
// Backpressure: fetch_req / lsu_req are held high until their completion strobe; no other flow control.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-low reset
//   start, start_pc       - launch pulse (accepted in IDLE or DONE) and entry PC
//   fetch_req/addr/valid/data - instruction fetch handshake (addr always equals pc)
//   instruction           - registered fetched word for the decoder
//   decoded_*             - decoder flags for the current instruction
//   branch_taken/target   - ALU branch resolution, sampled in EXECUTE
//   lsu_req, lsu_done     - load/store unit handshake
//   warp_state, pc, done, fetch_error, retired_count - status

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_controller #(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int INSTR_WIDTH   = 32,
    parameter int FETCH_TIMEOUT = 255,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_pc,
    output logic                   fetch_req,
    output logic [ADDR_WIDTH-1:0]  fetch_addr,
    input  logic                   fetch_valid,
    input  logic [INSTR_WIDTH-1:0] fetch_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   decoded_mem_access,
    input  logic                   decoded_halt,
    input  logic                   decoded_branch,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   lsu_req,
    input  logic                   lsu_done,
    output logic [2:0]             warp_state,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   done,
    output logic                   fetch_error,
    output logic [DATA_WIDTH-1:0]  retired_count
);

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_e;

    // The counter only needs to reach FETCH_TIMEOUT-1: the stalled cycle that
    // sees that value is the last one allowed.
    localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

    warp_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  npc_q, npc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0]  ret_q, ret_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WARP_IDLE;
            pc_q    <= '0;
            npc_q   <= '0;
            instr_q <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        ret_d   = ret_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            WARP_IDLE, WARP_DONE: begin
                if (start) begin
                    state_d = WARP_FETCH;
                    pc_d    = start_pc;
                    ret_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            WARP_FETCH: begin
                // A valid arriving on the final allowed cycle still wins.
                if (fetch_valid) begin
                    instr_d = fetch_data;
                    cnt_d   = '0;
                    state_d = WARP_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WARP_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WARP_DECODE: state_d = WARP_REQUEST;
            WARP_REQUEST: state_d = decoded_mem_access ? WARP_WAIT : WARP_EXECUTE;
            WARP_WAIT: begin
                if (lsu_done) state_d = WARP_EXECUTE;
            end
            WARP_EXECUTE: begin
                // Branch outcome is only valid now, so the next PC is captured
                // here and applied one cycle later in UPDATE.
                npc_d   = (decoded_branch && branch_taken) ? branch_target
                                                            : pc_q + ADDR_WIDTH'(1);
                state_d = WARP_UPDATE;
            end
            WARP_UPDATE: begin
                pc_d    = npc_q;
                ret_d   = ret_q + DATA_WIDTH'(1);
                state_d = decoded_halt ? WARP_DONE : WARP_FETCH;
            end
            default: state_d = WARP_IDLE;
        endcase
    end

    assign fetch_req     = (state_q == WARP_FETCH);
    assign lsu_req       = (state_q == WARP_WAIT);
    assign done          = (state_q == WARP_DONE);
    assign fetch_addr    = pc_q;
    assign pc            = pc_q;
    assign instruction   = instr_q;
    assign retired_count = ret_q;
    assign fetch_error   = err_q;
    assign warp_state    = state_q;

endmodule
